sha256_stream: RTL
==================

// Module: sha256_stream
// PURPOSE
//   Multi-block SHA-256/SHA-224 engine with chaining and valid/ready streaming on input and output.
//   Consumes pre-padded 512-bit blocks; the host marks the first and last block of each message.
//   Rounds per cycle is a parameter (area/latency trade).
//   Sits between the padding/DMA front-end and the digest consumer.
// PARAMETERS
//   RPC      1   SHA rounds per clock; legal 1,2,4,8 (must divide 64); NR = 64/RPC round cycles
//   MODE224  0   1 = SHA-224 IV, digest = top 224 bits of H; 0 = SHA-256
//   CNT_W    16  width of per-message block counter
//   DW = MODE224 ? 224 : 256 (derived)
// PORTS
//   clk        in   1       clock, rising edge
//   rst        in   1       synchronous reset, active-high
//   blk_valid  in   1       input block valid
//   blk_ready  out  1       engine can accept a block
//   blk_data   in   512     padded block; bits [511:480] = W0
//   blk_first  in   1       block starts a new message (load IV)
//   blk_last   in   1       block ends message (emit digest)
//   dig_valid  out  1       digest valid
//   dig_ready  in   1       consumer accepts digest
//   dig_data   out  DW      digest, H0 in MSBs
//   busy       out  1       state != IDLE
//   blk_count  out  CNT_W   blocks absorbed in the current message
// BEHAVIOUR
//   Reset (rst=1 at clk edge, any state): state=IDLE, blk_ready=1, dig_valid=0, dig_data=0, busy=0,
//     blk_count=0, H0..H7 = IV of selected mode; an in-flight block or pending digest is discarded.
//   FSM: IDLE -> ROUND -> FINAL -> (OUT | IDLE); OUT -> IDLE.
//   IDLE: blk_ready=1. Accept = blk_valid & blk_ready. On accept: latch W[0..15] from blk_data;
//     chain = blk_first ? IV : H; a..h <= chain; H <= chain; latch last flag; round ctr=0; -> ROUND.
//   ROUND: RPC compressions/cycle, message schedule in a 16-word shift window; after NR cycles -> FINAL.
//   FINAL (1 cycle): H[i] <= H[i] + working[i], all mod 2^32; blk_count <= (first ? 1 : blk_count+1),
//     saturating at 2^CNT_W-1.
//     If last: dig_data <= H' (truncated per MODE224), dig_valid=1, -> OUT; else -> IDLE.
//   Latency: dig_valid rises NR+1 cycles after the accept edge (RPC=1: 65; RPC=4: 17).
//     Block throughput: one block per NR+2 cycles when not last.
//   OUT: blk_ready=0; dig_valid/dig_data held stable until dig_valid & dig_ready; then dig_valid=0,
//     -> IDLE the same edge. No combinational path blk_valid->blk_ready or dig_ready->dig_valid.
//   blk_ready is 0 in ROUND/FINAL/OUT; blk_data/flags may change freely while blk_ready=0.
//   blk_first & blk_last both 1: single-block message.
//   blk_first=0 with no prior first since reset: chain = H = IV (behaves as first; counter starts at 1).
//   blk_first=0 after a completed last: continues from final H (length-extension use); not an error.
//   blk_first=1 mid-message: previous chain abandoned, IV reloaded, blk_count restarts at 1.
//   dig_data retains the last digest after handshake until the next FINAL with last=1, or reset.
// TESTING
//   1 ""  : 1 block 0x80..00, first=last=1 -> dig_data=e3b0c442...7852b855, valid at accept+65 (RPC=1).
//   2 "abc": 0x61626380..018 -> ba7816bf...f20015ad; MODE224=1 -> 23097d22...e36c9da7.
//   3 448-bit "abcdbcdecdefdefg..nopq", 2 blocks (first, then last) -> 248d6a61...19db06c1; blk_count=2;
//     no dig_valid after block 1.
//   4 Backpressure: hold dig_ready=0 for 20 cycles with blk_valid=1 -> dig_data stable, blk_ready=0,
//     next block accepted only after digest handshake; its digest still correct.
//   5 Reset mid-ROUND (cycle 30) -> next edge: IDLE, blk_ready=1, dig_valid=0; then "abc" hashes correctly.
//   6 RPC=4 and RPC=8 builds: tests 1-3 pass with dig_valid at accept+17 / accept+9.

Source files
------------

// File: rtl/sha256_stream.sv
// sha256_stream: multi-block SHA-256 / SHA-224 compression engine.
//   Accepts pre-padded 512-bit blocks over a valid/ready handshake and
//   chains the hash state across the blocks of a message. On the block
//   flagged last, it presents the digest over a second valid/ready
//   handshake. RPC rounds are evaluated per clock, so one block takes
//   NR = 64/RPC round cycles.
// Parameters:
//   RPC      rounds per clock (1, 2, 4, 8)
//   MODE224  1 = SHA-224 IV and 224-bit digest, 0 = SHA-256
//   CNT_W    width of the per-message block counter
// Ports:
//   clk, rst            clock (rising edge), synchronous active-high reset
//   blk_valid/ready     input block handshake
//   blk_data            padded block, W0 in bits [511:480]
//   blk_first/last      message delimiters for the offered block
//   dig_valid/ready     digest handshake
//   dig_data            digest, H0 in the MSBs
//   busy                engine not idle
//   blk_count           blocks absorbed in the current message (saturating)
module sha256_stream #(
   parameter int unsigned RPC     = 1,
   parameter int unsigned MODE224 = 0,
   parameter int unsigned CNT_W   = 16
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  blk_valid,
   output logic                                  blk_ready,
   input  logic [511:0]                          blk_data,
   input  logic                                  blk_first,
   input  logic                                  blk_last,
   output logic                                  dig_valid,
   input  logic                                  dig_ready,
   output logic [(MODE224 != 0 ? 224 : 256)-1:0] dig_data,
   output logic                                  busy,
   output logic [CNT_W-1:0]                      blk_count
);

   localparam int unsigned DW       = (MODE224 != 0) ? 224 : 256;
   localparam int unsigned NR       = 64 / RPC;
   localparam logic [5:0]  RND_LAST = 6'(NR - 1);

   localparam logic [255:0] IV = (MODE224 != 0) ?
      256'hc1059ed8_367cd507_3070dd17_f70e5939_ffc00b31_68581511_64f98fa7_befa4fa4 :
      256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

   localparam logic [31:0] K [0:63] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   typedef enum logic [1:0] {S_IDLE, S_ROUND, S_FINAL, S_OUT} state_t;

   function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [31:0] bsig0(input logic [31:0] x);
      return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
   endfunction

   function automatic logic [31:0] bsig1(input logic [31:0] x);
      return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
   endfunction

   function automatic logic [31:0] ssig0(input logic [31:0] x);
      return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
   endfunction

   function automatic logic [31:0] ssig1(input logic [31:0] x);
      return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
   endfunction

   state_t            state_q, state_nx;
   logic [255:0]      h_q;      // chaining value, H0 in MSBs
   logic [255:0]      st_q;     // working variables a..h, a in MSBs
   logic [15:0][31:0] w_q;      // schedule window, w_q[0] = W of next round
   logic [5:0]        rnd_q;
   logic              first_q, last_q;

   logic [255:0]      st_nx, h_sum, chain;
   logic [15:0][31:0] w_nx, tw;
   logic [31:0]       ra, rb, rc, rd, re, rf, rg, rh, t1, t2, wn;
   logic [5:0]        kidx;

   // Without an explicit first, H still holds IV after reset, so chaining
   // from H covers the "first block since reset" case automatically.
   assign chain = blk_first ? IV : h_q;

   // RPC unrolled rounds; the window slides one word per round and the
   // newly computed word enters at the top.
   always_comb begin
      {ra, rb, rc, rd, re, rf, rg, rh} = st_q;
      tw   = w_q;
      t1   = '0;
      t2   = '0;
      wn   = '0;
      kidx = '0;
      for (int unsigned r = 0; r < RPC; r++) begin
         kidx = 6'(int'(rnd_q) * int'(RPC) + int'(r));
         t1 = rh + bsig1(re) + ((re & rf) ^ (~re & rg)) + K[kidx] + tw[0];
         t2 = bsig0(ra) + ((ra & rb) ^ (ra & rc) ^ (rb & rc));
         rh = rg;
         rg = rf;
         rf = re;
         re = rd + t1;
         rd = rc;
         rc = rb;
         rb = ra;
         ra = t1 + t2;
         wn = ssig1(tw[14]) + tw[9] + ssig0(tw[1]) + tw[0];
         tw = {wn, tw[15:1]};
      end
      st_nx = {ra, rb, rc, rd, re, rf, rg, rh};
      w_nx  = tw;
   end

   always_comb begin
      h_sum = '0;
      for (int unsigned i = 0; i < 8; i++) begin
         h_sum[255 - 32*i -: 32] = h_q[255 - 32*i -: 32] + st_q[255 - 32*i -: 32];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_nx;
   end

   always_comb begin
      state_nx  = state_q;
      blk_ready = 1'b0;
      dig_valid = 1'b0;
      busy      = 1'b1;
      case (state_q)
         S_IDLE: begin
            blk_ready = 1'b1;
            busy      = 1'b0;
            if (blk_valid) state_nx = S_ROUND;
         end
         S_ROUND: if (rnd_q == RND_LAST) state_nx = S_FINAL;
         S_FINAL: state_nx = last_q ? S_OUT : S_IDLE;
         S_OUT: begin
            dig_valid = 1'b1;
            if (dig_ready) state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         h_q       <= IV;
         st_q      <= '0;
         w_q       <= '0;
         rnd_q     <= '0;
         first_q   <= 1'b0;
         last_q    <= 1'b0;
         blk_count <= '0;
         dig_data  <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (blk_valid) begin
                  for (int unsigned i = 0; i < 16; i++) begin
                     w_q[i] <= blk_data[511 - 32*i -: 32];
                  end
                  st_q    <= chain;
                  h_q     <= chain;
                  first_q <= blk_first;
                  last_q  <= blk_last;
                  rnd_q   <= '0;
               end
            end
            S_ROUND: begin
               st_q  <= st_nx;
               w_q   <= w_nx;
               rnd_q <= rnd_q + 6'd1;
            end
            S_FINAL: begin
               h_q <= h_sum;
               if (first_q)            blk_count <= CNT_W'(1);
               else if (blk_count != '1) blk_count <= blk_count + CNT_W'(1);
               if (last_q) dig_data <= h_sum[255 -: DW];
            end
            default: ;
         endcase
      end
   end

endmodule
